fetch_seq: RTL and testbench
============================

# fetch_seq

Fetch/issue sequencer for the single-issue core. Owns the PC, fetches one 32-bit instruction word at a time over a request/grant/response memory port, and holds it in an instruction register that drives the combinational `decoder`. Presents the held instruction downstream with a valid/ready handshake, accepts branch redirects, and halts permanently when the decoder flags an illegal encoding.

## Interface
- `PC_W`, 32, PC and fetch-address width.
- `RESET_PC`, 32'h0, PC value after reset (width `PC_W`).
- `PC_INC`, 4, PC increment per issued instruction.

- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `start_i` in 1: leave IDLE and begin fetching.
- `imem_req_o` out 1: fetch request.
- `imem_addr_o` out PC_W: fetch address, equals PC.
- `imem_gnt_i` in 1: request accepted this cycle.
- `imem_rvalid_i` in 1: response data valid.
- `imem_rdata_i` in 32: response word.
- `instr_o` out 32: instruction register, wired to decoder `instr_i`.
- `dec_exception_i` in 1: decoder exception for `instr_o`.
- `issue_valid_o` out 1: held instruction ready to issue.
- `issue_ready_i` in 1: downstream accepts.
- `issue_pc_o` out PC_W: PC of the held instruction.
- `redirect_i` in 1: branch/jump redirect.
- `redirect_pc_i` in PC_W: redirect target.
- `busy_o` out 1: state is not IDLE and not HALT.
- `halted_o` out 1: state is HALT.
- `exc_pc_o` out PC_W: PC of the faulting instruction, valid when `halted_o`.

## Operation
- States: IDLE, REQ, WAIT, ISSUE, HALT. Reset → IDLE, PC=`RESET_PC`, drop=0.
- IDLE: `start_i` → REQ. Other inputs are ignored, including `redirect_i`.
- REQ: `imem_req_o`=1. On `imem_gnt_i` → WAIT.
- WAIT: on `imem_rvalid_i`, if drop=0, latch `imem_rdata_i` into `instr_o` and go to ISSUE. If drop=1, discard the word, clear drop and go to REQ. Exactly one response arrives per grant.
- ISSUE: `issue_valid_o` = !`dec_exception_i`. This gating is combinational.
  - `dec_exception_i` → HALT and capture `exc_pc_o`=PC. There is no handshake.
  - `issue_valid_o && issue_ready_i` → PC+=`PC_INC` (modulo 2^PC_W), then REQ.
- HALT: all request and issue outputs are 0. Only `rst_i` exits.
- Redirect (REQ/WAIT/ISSUE) sets PC:=`redirect_pc_i`. It has priority over the increment.
  - REQ, no grant: stay in REQ. The next cycle requests the new address.
  - REQ with grant in the same cycle: the grant belongs to the old address, so set drop=1 and go to WAIT.
  - WAIT: set drop=1, or if `imem_rvalid_i` arrives in the same cycle, discard that word and go to REQ.
  - ISSUE with handshake in the same cycle: the instruction counts as issued, then go to REQ at the target.
  - ISSUE without handshake: discard the held instruction and go to REQ.
  - `dec_exception_i` in ISSUE has priority over redirect.
- `instr_o` holds its value outside WAIT→ISSUE loads.

## Timing
- Reset values:
  - `imem_req_o`, `issue_valid_o`, `busy_o`, `halted_o` = 0.
  - `imem_addr_o`, `issue_pc_o` = `RESET_PC`.
  - `instr_o` = 0, `exc_pc_o` = 0.
- All outputs are registered or state-decoded, except `issue_valid_o`, which is gated by `dec_exception_i`.
- Best-case latency:
  - `start_i` in cycle 0.
  - `imem_req_o` in cycle 1, with grant in cycle 1.
  - WAIT in cycle 2, with rvalid in cycle 2.
  - `issue_valid_o` in cycle 3.
  - Peak throughput is 1 instruction per 3 cycles.
- `imem_addr_o` is stable while `imem_req_o`=1 and no redirect is taken.
- `rst_i` mid-operation returns to IDLE next cycle. An outstanding response after reset is ignored because IDLE does not sample `imem_rvalid_i`.

## Configuration
- `FETCH_SEQ_PERF_EN`:
  - When defined, adds output `issued_cnt_o` (32 bits), reset 0. It increments on each issue handshake and wraps at 2^32. It also adds `drop_cnt_o` (16 bits, saturating), which counts discarded responses and discarded held instructions.
  - When undefined, neither port nor the counters exist.

## Test plan
- Zero-wait memory, `start_i`, ready tied high: issue PCs are 0x0, 0x4, 0x8, with `issue_valid_o` in cycles 3, 6, 9.
- Grant delayed 2 cycles, rvalid delayed 3 cycles: `imem_addr_o` stays constant throughout, and one issue occurs at the correct PC.
- Redirect to 0x100 during WAIT: that response is dropped, the next request is for 0x100, and `drop_cnt_o`=1 when `FETCH_SEQ_PERF_EN` is defined.
- Redirect to 0x40 in the same cycle as an ISSUE handshake at PC 0x8: the instruction issues once, the next fetch is for 0x40, and `issued_cnt_o` increments.
- Decoder exception on the word at 0xC: `issue_valid_o` stays 0, `halted_o`=1, `exc_pc_o`=0xC, and no further requests occur; `rst_i` returns to IDLE with PC=0.
- `issue_ready_i` low for 5 cycles in ISSUE: `issue_valid_o` stays high, `instr_o` and `issue_pc_o` stay stable, and there are no requests.

Source files
------------

// File: rtl/fetch_seq.sv
// Fetch/issue sequencer: owns the PC, fetches one word per request/grant/response
// round trip, holds it for issue, handles redirects and halts on illegal encodings.
// Optional performance counters are enabled by defining FETCH_SEQ_PERF_EN.
module fetch_seq #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PC_INC   = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic            imem_req_o,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic [31:0]     instr_o,
    input  logic            dec_exception_i,
    output logic            issue_valid_o,
    input  logic            issue_ready_i,
    output logic [PC_W-1:0] issue_pc_o,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    output logic            busy_o,
    output logic            halted_o,
    output logic [PC_W-1:0] exc_pc_o
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [31:0]     issued_cnt_o,
    output logic [15:0]     drop_cnt_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t            state_reg, state_next;
    logic [PC_W-1:0]   pc_reg, pc_next;
    logic              drop_reg, drop_next;
    logic [31:0]       instr_reg, instr_next;
    logic [PC_W-1:0]   exc_pc_reg, exc_pc_next;
    logic              handshake;

    assign handshake = (state_reg == S_ISSUE) && !dec_exception_i && issue_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= S_IDLE;
            pc_reg     <= RESET_PC;
            drop_reg   <= 1'b0;
            instr_reg  <= '0;
            exc_pc_reg <= '0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            drop_reg   <= drop_next;
            instr_reg  <= instr_next;
            exc_pc_reg <= exc_pc_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        drop_next   = drop_reg;
        instr_next  = instr_reg;
        exc_pc_next = exc_pc_reg;
        case (state_reg)
            S_IDLE: begin
                if (start_i) state_next = S_REQ;
            end
            S_REQ: begin
                if (redirect_i) pc_next = redirect_pc_i;
                if (imem_gnt_i) begin
                    // A grant coinciding with a redirect belongs to the old address.
                    if (redirect_i) drop_next = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_i) begin
                    pc_next = redirect_pc_i;
                    if (imem_rvalid_i) begin
                        drop_next  = 1'b0;
                        state_next = S_REQ;
                    end else begin
                        drop_next = 1'b1;
                    end
                end else if (imem_rvalid_i) begin
                    if (drop_reg) begin
                        drop_next  = 1'b0;
                        state_next = S_REQ;
                    end else begin
                        instr_next = imem_rdata_i;
                        state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // Exception beats redirect; redirect beats the sequential increment.
                if (dec_exception_i) begin
                    exc_pc_next = pc_reg;
                    state_next  = S_HALT;
                end else if (redirect_i) begin
                    pc_next    = redirect_pc_i;
                    state_next = S_REQ;
                end else if (issue_ready_i) begin
                    pc_next    = pc_reg + PC_W'(PC_INC);
                    state_next = S_REQ;
                end
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign imem_req_o    = (state_reg == S_REQ);
    assign imem_addr_o   = pc_reg;
    assign issue_pc_o    = pc_reg;
    assign instr_o       = instr_reg;
    assign issue_valid_o = (state_reg == S_ISSUE) && !dec_exception_i;
    assign busy_o        = (state_reg != S_IDLE) && (state_reg != S_HALT);
    assign halted_o      = (state_reg == S_HALT);
    assign exc_pc_o      = exc_pc_reg;

`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] issued_cnt_reg;
    logic [15:0] drop_cnt_reg;
    logic        drop_evt;

    // Discarded response words plus held instructions thrown away by a redirect.
    assign drop_evt = ((state_reg == S_WAIT) && imem_rvalid_i && (drop_reg || redirect_i)) ||
                      ((state_reg == S_ISSUE) && !dec_exception_i && redirect_i && !issue_ready_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            issued_cnt_reg <= '0;
            drop_cnt_reg   <= '0;
        end else begin
            if (handshake) issued_cnt_reg <= issued_cnt_reg + 32'd1;
            if (drop_evt && (drop_cnt_reg != 16'hFFFF)) drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    assign issued_cnt_o = issued_cnt_reg;
    assign drop_cnt_o   = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: a scoreboard of expected issues filled by each
// scenario and drained by a handshake monitor, plus a delay-configurable memory model.
module tb_fetch_seq;
    localparam int PC_W = 32;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            start_i;
    logic            imem_req_o;
    logic [PC_W-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [31:0]     imem_rdata_i;
    logic [31:0]     instr_o;
    logic            dec_exception_i;
    logic            issue_valid_o;
    logic            issue_ready_i;
    logic [PC_W-1:0] issue_pc_o;
    logic            redirect_i;
    logic [PC_W-1:0] redirect_pc_i;
    logic            busy_o;
    logic            halted_o;
    logic [PC_W-1:0] exc_pc_o;
`ifdef FETCH_SEQ_PERF_EN
    logic [31:0]     issued_cnt_o;
    logic [15:0]     drop_cnt_o;
`endif

    always #5 clk = ~clk;

    fetch_seq #(.PC_W(PC_W), .RESET_PC(32'h0), .PC_INC(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .instr_o(instr_o), .dec_exception_i(dec_exception_i),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i), .issue_pc_o(issue_pc_o),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .busy_o(busy_o), .halted_o(halted_o), .exc_pc_o(exc_pc_o)
`ifdef FETCH_SEQ_PERF_EN
        , .issued_cnt_o(issued_cnt_o), .drop_cnt_o(drop_cnt_o)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int issues = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'h1300_0000 ^ a;
    endfunction

    // Decoder stand-in: flags the word fetched from exc_addr as illegal.
    logic        exc_en = 1'b0;
    logic [31:0] exc_addr = 32'h0;
    assign dec_exception_i = exc_en && (instr_o == word_of(exc_addr));

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          at;
    } exp_t;
    exp_t sb[$];

    task automatic push_exp(input logic [31:0] pc, input int at);
        exp_t e;
        e.pc = pc;
        e.instr = word_of(pc);
        e.at = at;
        sb.push_back(e);
    endtask

    // Memory model: grant after gnt_delay waiting cycles, response rv_delay cycles later.
    typedef struct {
        logic [31:0] addr;
        int          cd;
    } resp_t;
    resp_t rq[$];
    int gnt_delay = 0;
    int rv_delay  = 0;

    initial begin
        int gcnt;
        resp_t r;
        gcnt = 0;
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            imem_rvalid_i = 1'b0;
            imem_gnt_i = 1'b0;
            if (rst_i) begin
                rq.delete();
                gcnt = 0;
            end else begin
                if (rq.size() > 0) begin
                    if (rq[0].cd == 0) begin
                        imem_rvalid_i = 1'b1;
                        imem_rdata_i = word_of(rq[0].addr);
                        void'(rq.pop_front());
                    end else begin
                        rq[0].cd = rq[0].cd - 1;
                    end
                end
                if (imem_req_o) begin
                    if (gcnt >= gnt_delay) begin
                        imem_gnt_i = 1'b1;
                        r.addr = imem_addr_o;
                        r.cd = rv_delay;
                        rq.push_back(r);
                        gcnt = 0;
                    end else begin
                        gcnt++;
                    end
                end else begin
                    gcnt = 0;
                end
            end
        end
    end

    // Handshake monitor: every issue is popped against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (issue_valid_o && issue_ready_i) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_issue: pc=%h instr=%h, no issue expected", issue_pc_o, instr_o);
                end else begin
                    e = sb.pop_front();
                    if (issue_pc_o !== e.pc || instr_o !== e.instr || (e.at >= 0 && cyc !== e.at)) begin
                        bad++;
                        $display("FAIL issue: got pc=%h instr=%h cyc=%0d, want pc=%h instr=%h cyc=%0d",
                                 issue_pc_o, instr_o, cyc, e.pc, e.instr, e.at);
                    end else begin
                        $display("issue ok: pc=%h instr=%h cyc=%0d", issue_pc_o, instr_o, cyc);
                    end
                end
                issues++;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        start_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        issue_ready_i = 1'b0;
        exc_en = 1'b0;
        gnt_delay = 0;
        rv_delay = 0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        sb.delete();
        issues = 0;
    endtask

    task automatic wait_issues(input int n, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (issues >= n) break;
        end
        total++;
        if (issues < n) begin
            bad++;
            $display("FAIL wait_issues: got %0d issues, want %0d within %0d cycles", issues, n, budget);
        end
    endtask

    task automatic check_drained(input string name);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drained: %0d expected issues left, want 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        total += 4;
        if (imem_req_o !== 1'b0 || issue_valid_o !== 1'b0) begin
            bad++; $display("FAIL reset_req_valid: req=%b valid=%b, want 0 0", imem_req_o, issue_valid_o);
        end
        if (busy_o !== 1'b0 || halted_o !== 1'b0) begin
            bad++; $display("FAIL reset_busy_halted: busy=%b halted=%b, want 0 0", busy_o, halted_o);
        end
        if (imem_addr_o !== 32'h0 || issue_pc_o !== 32'h0) begin
            bad++; $display("FAIL reset_pc: addr=%h issue_pc=%h, want 0 0", imem_addr_o, issue_pc_o);
        end
        if (instr_o !== 32'h0 || exc_pc_o !== 32'h0) begin
            bad++; $display("FAIL reset_instr_exc: instr=%h exc_pc=%h, want 0 0", instr_o, exc_pc_o);
        end
`ifdef FETCH_SEQ_PERF_EN
        total++;
        if (issued_cnt_o !== 32'd0 || drop_cnt_o !== 16'd0) begin
            bad++; $display("FAIL reset_cnt: issued=%0d drop=%0d, want 0 0", issued_cnt_o, drop_cnt_o);
        end
`endif
        $display("reset checked");
    endtask

    task automatic test_stream();
        int t0;
        do_reset();
        issue_ready_i = 1'b1;
        t0 = cyc;
        push_exp(32'h0, t0 + 3);
        push_exp(32'h4, t0 + 6);
        push_exp(32'h8, t0 + 9);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        total++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            bad++; $display("FAIL stream_first_req: req=%b addr=%h, want 1 0", imem_req_o, imem_addr_o);
        end
        wait_issues(3, 40);
        issue_ready_i = 1'b0;
        check_drained("stream");
    endtask

    task automatic test_slow();
        int req_cycles;
        int i;
        do_reset();
        gnt_delay = 2;
        rv_delay = 3;
        push_exp(32'h0, -1);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        req_cycles = 0;
        for (i = 0; i < 30; i++) begin
            if (issue_valid_o) break;
            if (imem_req_o) begin
                req_cycles++;
                total++;
                if (imem_addr_o !== 32'h0) begin
                    bad++; $display("FAIL slow_addr_stable: addr=%h, want 0", imem_addr_o);
                end
            end
            @(negedge clk);
        end
        total++;
        if (req_cycles != 3) begin
            bad++; $display("FAIL slow_req_cycles: got %0d, want 3", req_cycles);
        end
        issue_ready_i = 1'b1;
        @(negedge clk);
        issue_ready_i = 1'b0;
        wait_issues(1, 5);
        check_drained("slow");
    endtask

    task automatic test_redirect_wait();
        int i;
        do_reset();
        rv_delay = 2;
        issue_ready_i = 1'b1;
        push_exp(32'h100, -1);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h100;
        @(negedge clk);
        redirect_i = 1'b0;
        for (i = 0; i < 10; i++) begin
            if (imem_req_o) break;
            @(negedge clk);
        end
        total++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
            bad++; $display("FAIL redir_wait_req: req=%b addr=%h, want 1 00000100", imem_req_o, imem_addr_o);
        end
        wait_issues(1, 20);
        issue_ready_i = 1'b0;
        check_drained("redir_wait");
`ifdef FETCH_SEQ_PERF_EN
        total++;
        if (drop_cnt_o !== 16'd1) begin
            bad++; $display("FAIL redir_wait_drop_cnt: got %0d, want 1", drop_cnt_o);
        end
`endif
    endtask

    task automatic test_redirect_issue();
        int t0;
        do_reset();
        issue_ready_i = 1'b1;
        t0 = cyc;
        push_exp(32'h0, t0 + 3);
        push_exp(32'h4, t0 + 6);
        push_exp(32'h8, t0 + 9);
        push_exp(32'h40, t0 + 12);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (8) @(negedge clk);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h40;
        @(negedge clk);
        redirect_i = 1'b0;
        total++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin
            bad++; $display("FAIL redir_issue_req: req=%b addr=%h, want 1 00000040", imem_req_o, imem_addr_o);
        end
        wait_issues(4, 20);
        issue_ready_i = 1'b0;
        check_drained("redir_issue");
`ifdef FETCH_SEQ_PERF_EN
        total++;
        if (issued_cnt_o !== 32'd4 || drop_cnt_o !== 16'd0) begin
            bad++; $display("FAIL redir_issue_cnt: issued=%0d drop=%0d, want 4 0", issued_cnt_o, drop_cnt_o);
        end
`endif
    endtask

    task automatic test_exception();
        do_reset();
        issue_ready_i = 1'b1;
        exc_en = 1'b1;
        exc_addr = 32'hC;
        push_exp(32'h0, -1);
        push_exp(32'h4, -1);
        push_exp(32'h8, -1);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (11) @(negedge clk);
        total++;
        if (issue_valid_o !== 1'b0 || busy_o !== 1'b1 || issue_pc_o !== 32'hC) begin
            bad++; $display("FAIL exc_gate: valid=%b busy=%b pc=%h, want 0 1 0000000c", issue_valid_o, busy_o, issue_pc_o);
        end
        @(negedge clk);
        total++;
        if (halted_o !== 1'b1 || busy_o !== 1'b0 || exc_pc_o !== 32'hC) begin
            bad++; $display("FAIL exc_halt: halted=%b busy=%b exc_pc=%h, want 1 0 0000000c", halted_o, busy_o, exc_pc_o);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (imem_req_o !== 1'b0 || issue_valid_o !== 1'b0) begin
                bad++; $display("FAIL exc_quiet: req=%b valid=%b, want 0 0", imem_req_o, issue_valid_o);
            end
            @(negedge clk);
        end
        check_drained("exc");
        do_reset();
        total++;
        if (halted_o !== 1'b0 || busy_o !== 1'b0 || imem_addr_o !== 32'h0 || exc_pc_o !== 32'h0) begin
            bad++; $display("FAIL exc_reset: halted=%b busy=%b addr=%h exc_pc=%h, want 0 0 0 0",
                            halted_o, busy_o, imem_addr_o, exc_pc_o);
        end
    endtask

    task automatic test_stall();
        int i;
        do_reset();
        push_exp(32'h0, -1);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (i = 0; i < 10; i++) begin
            if (issue_valid_o) break;
            @(negedge clk);
        end
        for (i = 0; i < 5; i++) begin
            total++;
            if (issue_valid_o !== 1'b1 || instr_o !== word_of(32'h0) || issue_pc_o !== 32'h0 || imem_req_o !== 1'b0) begin
                bad++; $display("FAIL stall_hold: valid=%b instr=%h pc=%h req=%b, want 1 %h 0 0",
                                issue_valid_o, instr_o, issue_pc_o, imem_req_o, word_of(32'h0));
            end
            @(negedge clk);
        end
        issue_ready_i = 1'b1;
        @(negedge clk);
        issue_ready_i = 1'b0;
        wait_issues(1, 5);
        check_drained("stall");
    endtask

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        issue_ready_i = 1'b0;
        test_reset();
        test_stream();
        test_slow();
        test_redirect_wait();
        test_redirect_issue();
        test_exception();
        test_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
